// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream FIFO into a 2-entry output buffer with ready/valid handshake.
// Optional delivered-word counter drain_cnt is enabled by the DRAIN_CNT_EN macro.
module fifo_drain_ctrl #(
  parameter int WORD_SIZE = 10,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 pop,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [WORD_SIZE-1:0] data_out
`ifdef DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0]     drain_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 infl;
  logic [WORD_SIZE-1:0] head;
  logic [WORD_SIZE-1:0] tail;
  logic [1:0]           occ;
  logic [1:0]           pend;
  logic                 xfer;
  logic                 head_ld_in;
  logic                 head_ld_tail;
  logic                 tail_ld_in;

  assign occ       = state;
  assign pend      = occ + {1'b0, infl};
  assign valid_out = (state != EMPTY);
  assign xfer      = valid_out && ready_in;
  assign data_out  = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      infl  <= 1'b0;
    end else begin
      state <= state_nxt;
      infl  <= pop;
    end
  end

  // Buffered plus in-flight words never exceed 2, so a pop is only issued
  // when a slot is free or is being freed by this cycle's transfer.
  always_comb begin
    state_nxt    = state;
    head_ld_in   = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld_in   = 1'b0;
    pop          = !reset && !fifo_empty &&
                   ((pend < 2'd2) || ((pend == 2'd2) && xfer));
    case (state)
      EMPTY: begin
        if (infl) begin
          state_nxt  = ONE;
          head_ld_in = 1'b1;
        end
      end
      ONE: begin
        case ({infl, xfer})
          2'b10: begin
            state_nxt  = FULL;
            tail_ld_in = 1'b1;
          end
          2'b01:   state_nxt  = EMPTY;
          2'b11:   head_ld_in = 1'b1;
          default: state_nxt  = ONE;
        endcase
      end
      FULL: begin
        if (xfer) begin
          head_ld_tail = 1'b1;
          if (infl) tail_ld_in = 1'b1;
          else      state_nxt  = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_ld_in)        head <= fifo_data_out;
      else if (head_ld_tail) head <= tail;
      if (tail_ld_in)        tail <= fifo_data_out;
    end
  end

`ifdef DRAIN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)     drain_cnt <= '0;
    else if (xfer) drain_cnt <= drain_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a queue-based upstream FIFO model feeds
// expected words to a monitor that checks order, backpressure stability and counts.
module tb_fifo_drain_ctrl;
  localparam int W  = 10;
  localparam int CW = 8;

  logic         clk;
  logic         reset;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         pop;
  logic         ready_in;
  logic         valid_out;
  logic [W-1:0] data_out;
`ifdef DRAIN_CNT_EN
  logic [CW-1:0] drain_cnt;
`endif

  fifo_drain_ctrl #(.WORD_SIZE(W), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .pop(pop),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out)
`ifdef DRAIN_CNT_EN
    ,
    .drain_cnt(drain_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int delivered = 0;
  logic         hold;
  logic [W-1:0] src[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of upstream FIFO behaviour; returns what the DUT showed this cycle.
  task automatic tick(output logic p, output logic v, output logic [W-1:0] d);
    logic r;
    logic [W-1:0] w;
    fifo_empty = hold || (src.size() == 0);
    @(negedge clk);
    p = pop; v = valid_out; d = data_out; r = reset;
    if (pop) chk("pop_legal", {31'd0, fifo_empty || reset}, 32'd0);
    @(posedge clk);
    #1;
    if (p && src.size() > 0) begin
      w = src.pop_front();
      fifo_data_out = w;
      exp_q.push_back(w);
      pops++;
    end else begin
      fifo_data_out = W'($urandom);
    end
    if (r) exp_q.delete();
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) src.push_back(W'($urandom));
  endtask

  // Monitor: compares every transfer against the scoreboard queue.
  initial begin
    logic         hold_prev;
    logic [W-1:0] hold_data;
    logic [CW-1:0] cnt_m;
    logic [W-1:0] e;
    hold_prev = 1'b0;
    hold_data = '0;
    cnt_m = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (hold_prev) chk("hold_stable", {21'd0, valid_out, data_out}, {21'd0, 1'b1, hold_data});
      chk("outstanding_le2", {31'd0, exp_q.size() <= 2}, 32'd1);
`ifdef DRAIN_CNT_EN
      chk("drain_cnt", {24'd0, drain_cnt}, {24'd0, cnt_m});
`endif
      if (!reset && valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", {22'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("order", {22'd0, data_out}, {22'd0, e});
          delivered++;
        end
      end
      if (reset) cnt_m = '0;
      else if (valid_out && ready_in) cnt_m = cnt_m + 1'b1;
      hold_prev = !reset && valid_out && !ready_in;
      hold_data = data_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic p, v;
    logic [W-1:0] d;
    logic [5:0] pop_pat;
    logic [5:0] val_pat;
    int base, dbase, vcnt;

    reset = 1'b1; hold = 1'b1; ready_in = 1'b1; fifo_data_out = '0;
    fifo_empty = 1'b1;
    repeat (2) tick(p, v, d);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(p, v, d);
      chk("idle_pop", {31'd0, p}, 32'd0);
      chk("idle_valid", {31'd0, v}, 32'd0);
      chk("idle_data", {22'd0, d}, 32'd0);
    end

    // Three words with a ready consumer: pop cycles 1-3, valid cycles 3-5.
    src.push_back(10'h001); src.push_back(10'h002); src.push_back(10'h003);
    hold = 1'b0;
    pop_pat = 6'b000111;
    val_pat = 6'b011100;
    dbase = delivered;
    for (int i = 0; i < 6; i++) begin
      tick(p, v, d);
      chk("seq3_pop", {31'd0, p}, {31'd0, pop_pat[i]});
      chk("seq3_valid", {31'd0, v}, {31'd0, val_pat[i]});
    end
    chk("seq3_count", delivered - dbase, 32'd3);

    // Backpressure: only two words may leave the FIFO.
    ready_in = 1'b0;
    push_words(5);
    base = pops;
    repeat (8) tick(p, v, d);
    chk("bp_pops", pops - base, 32'd2);
    chk("bp_valid", {31'd0, v}, 32'd1);
    ready_in = 1'b1;
    dbase = delivered;
    repeat (10) tick(p, v, d);
    chk("bp_delivered", delivered - dbase, 32'd5);
    chk("bp_src_empty", src.size(), 32'd0);

    // fifo_empty rises while a word is in flight.
    src.push_back(10'h2A5);
    dbase = delivered;
    tick(p, v, d);
    chk("infl_pop", {31'd0, p}, 32'd1);
    hold = 1'b1;
    repeat (4) tick(p, v, d);
    chk("infl_delivered", delivered - dbase, 32'd1);
    hold = 1'b0;

    // Reset with a full buffer discards both words.
    ready_in = 1'b0;
    push_words(3);
    repeat (4) tick(p, v, d);
    chk("full_valid", {31'd0, v}, 32'd1);
    reset = 1'b1;
    tick(p, v, d);
    chk("rst_pop", {31'd0, p}, 32'd0);
    reset = 1'b0;
    hold = 1'b1;
    tick(p, v, d);
    chk("rst_valid", {31'd0, v}, 32'd0);
    chk("rst_data", {22'd0, d}, 32'd0);
    hold = 1'b0;
    ready_in = 1'b1;
    repeat (6) tick(p, v, d);
    chk("rst_remaining", exp_q.size(), 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && src.size() < 8) push_words($urandom_range(1, 3));
      hold     = ($urandom_range(0, 3) == 0);
      ready_in = ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 149) == 0);
      tick(p, v, d);
    end
    reset = 1'b0; hold = 1'b0; ready_in = 1'b1;
    repeat (20) tick(p, v, d);
    chk("rand_drained", exp_q.size() + src.size(), 32'd0);

    // Throughput: one word per cycle after a two-cycle first-word latency.
    reset = 1'b1;
    tick(p, v, d);
    reset = 1'b0;
    push_words(30);
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick(p, v, d);
      if (i == 1) chk("first_latency", {31'd0, v}, 32'd0);
      if (i >= 2 && v) vcnt++;
    end
    chk("throughput", vcnt, 32'd23);
    repeat (10) tick(p, v, d);

    // 257 transfers from reset wrap an 8-bit counter to 1.
    reset = 1'b1;
    tick(p, v, d);
    reset = 1'b0;
    push_words(257);
    dbase = delivered;
    repeat (270) tick(p, v, d);
    chk("wrap_delivered", delivered - dbase, 32'd257);
`ifdef DRAIN_CNT_EN
    chk("drain_cnt_wrap", {24'd0, drain_cnt}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
